cronometro_demux: RTL and testbench

CRONOMETRO_DEMUX -- requirements
Module: cronometro_demux

---
 rtl/cronometro_demux.sv | 144 ++++++++++++++
 tb/tb_cronometro_demux.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cronometro_demux.sv
// Demultiplexes a scanned 4-digit BCD display bus back into per-digit registers.
// A frame is one in-order pass of sel 0,1,2,3. The block locks onto the scan order
// after LOCK_FRAMES clean frames, and from then on commits every clean frame.
module cronometro_demux #(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_valid,
  output logic       locked,
  output logic       seq_err,
  output logic       bcd_err
);

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] LOCKING  = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;

  localparam logic [3:0] LockFrames = 4'(LOCK_FRAMES);

  logic [1:0] state_q, state_d;
  logic [1:0] expected_q, expected_d;
  logic [3:0] good_frames_q, good_frames_d;
  logic [3:0] good_inc;
  logic       frame_bad_q, frame_bad_d;
  logic [3:0] shadow0_q, shadow1_q, shadow2_q;
  logic       frame_valid_q, seq_err_q, bcd_err_q;

  logic [3:0] nib;
  logic       nib_bad;
  logic       capture;
  logic       commit;
  logic       seq_err_d;

  assign nib     = {A, B, C, D};
  assign nib_bad = (nib > 4'd9);
  // Capture while tracking, and on the sel==0 cycle that leaves UNLOCKED.
  assign capture = (state_q != UNLOCKED) || (sel == 2'd0);

  assign locked      = (state_q == LOCKED);
  assign frame_valid = frame_valid_q;
  assign seq_err     = seq_err_q;
  assign bcd_err     = bcd_err_q;

  // Next-state: sequence tracking, lock counting and commit decision.
  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    good_frames_d = good_frames_q;
    frame_bad_d   = frame_bad_q;
    good_inc      = (good_frames_q == 4'hF) ? 4'hF : good_frames_q + 4'd1;
    commit        = 1'b0;
    seq_err_d     = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (sel == 2'd0) begin
          state_d       = LOCKING;
          expected_d    = 2'd1;
          good_frames_d = 4'd0;
          frame_bad_d   = nib_bad;
        end
      end
      default: begin
        if (sel != expected_q) begin
          seq_err_d     = 1'b1;
          state_d       = UNLOCKED;
          good_frames_d = 4'd0;
        end else begin
          expected_d  = expected_q + 2'd1;
          // A new frame starts at sel==0; its bad flag restarts with this nibble.
          frame_bad_d = (sel == 2'd0) ? nib_bad : (frame_bad_q | nib_bad);
          if (sel == 2'd3) begin
            if (!(frame_bad_q || nib_bad)) begin
              if (state_q == LOCKED) begin
                commit = 1'b1;
              end else begin
                good_frames_d = good_inc;
                if (good_inc >= LockFrames) begin
                  state_d = LOCKED;
                  commit  = 1'b1;
                end
              end
            end else if (state_q == LOCKING) begin
              good_frames_d = 4'd0;
            end
          end
        end
      end
    endcase
  end

  // State, shadow and output registers; reset wins over any same-edge event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= UNLOCKED;
      expected_q    <= 2'd0;
      good_frames_q <= 4'd0;
      frame_bad_q   <= 1'b0;
      shadow0_q     <= 4'd0;
      shadow1_q     <= 4'd0;
      shadow2_q     <= 4'd0;
      digit0        <= 4'd0;
      digit1        <= 4'd0;
      digit2        <= 4'd0;
      digit3        <= 4'd0;
      frame_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      bcd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      good_frames_q <= good_frames_d;
      frame_bad_q   <= frame_bad_d;
      frame_valid_q <= commit;
      seq_err_q     <= seq_err_d;
      if (capture) begin
        case (sel)
          2'd0:    shadow0_q <= nib;
          2'd1:    shadow1_q <= nib;
          2'd2:    shadow2_q <= nib;
          default: ;
        endcase
        if (nib_bad) bcd_err_q <= 1'b1;
      end
      // digit3 comes straight from the bus: its nibble arrives on the commit edge.
      if (commit) begin
        digit0 <= shadow0_q;
        digit1 <= shadow1_q;
        digit2 <= shadow2_q;
        digit3 <= nib;
      end
    end
  end

endmodule

// File: tb/tb_cronometro_demux.sv
// Directed bench for cronometro_demux: lock, mid-frame start, sequence break,
// BCD error, long clean run and reset during a commit.
module tb_cronometro_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sel;
  logic       a, b, c, d;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       frame_valid, locked, seq_err, bcd_err;
  logic [3:0] d1_digit0, d1_digit1, d1_digit2, d1_digit3;
  logic       d1_frame_valid, d1_locked, d1_seq_err, d1_bcd_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cronometro_demux #(.LOCK_FRAMES(2)) u_dut (
    .clk(clk), .reset(reset), .sel(sel), .A(a), .B(b), .C(c), .D(d),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .frame_valid(frame_valid), .locked(locked), .seq_err(seq_err), .bcd_err(bcd_err)
  );

  // Single-frame lock variant fed from the same bus.
  cronometro_demux #(.LOCK_FRAMES(1)) u_dut1 (
    .clk(clk), .reset(reset), .sel(sel), .A(a), .B(b), .C(c), .D(d),
    .digit0(d1_digit0), .digit1(d1_digit1), .digit2(d1_digit2), .digit3(d1_digit3),
    .frame_valid(d1_frame_valid), .locked(d1_locked), .seq_err(d1_seq_err),
    .bcd_err(d1_bcd_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one scan slot at the falling edge, return 1ns after the sampling edge.
  task automatic step(input logic [1:0] s, input logic [3:0] n);
    @(negedge clk);
    sel = s;
    {a, b, c, d} = n;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] n0, input logic [3:0] n1,
                       input logic [3:0] n2, input logic [3:0] n3);
    step(2'd0, n0);
    step(2'd1, n1);
    step(2'd2, n2);
    step(2'd3, n3);
  endtask

  task automatic check_digits(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3);
    check({tag, ".d0"}, 32'(digit0), 32'(e0));
    check({tag, ".d1"}, 32'(digit1), 32'(e1));
    check({tag, ".d2"}, 32'(digit2), 32'(e2));
    check({tag, ".d3"}, 32'(digit3), 32'(e3));
  endtask

  initial begin
    logic [3:0] v0, v1, v2, v3;
    reset = 1'b1;
    sel = 2'd0;
    {a, b, c, d} = 4'd0;
    step(2'd0, 4'd5);
    step(2'd1, 4'd5);
    check_digits("rst", 4'd0, 4'd0, 4'd0, 4'd0);
    check("rst.fv", 32'(frame_valid), 0);
    check("rst.lock", 32'(locked), 0);
    check("rst.seq", 32'(seq_err), 0);
    check("rst.bcd", 32'(bcd_err), 0);

    // Release reset mid-frame: sel 2,3 must be ignored.
    @(negedge clk);
    reset = 1'b0;
    step(2'd2, 4'd7);
    step(2'd3, 4'd7);
    check("mid.fv", 32'(frame_valid), 0);
    check("mid.seq", 32'(seq_err), 0);
    check("mid.lock", 32'(locked), 0);
    frame(4'd1, 4'd2, 4'd3, 4'd4);
    check("f1.fv", 32'(frame_valid), 0);
    check("f1.lock", 32'(locked), 0);
    check_digits("f1", 4'd0, 4'd0, 4'd0, 4'd0);
    check("lf1.lock", 32'(d1_locked), 1);
    check("lf1.fv", 32'(d1_frame_valid), 1);
    check("lf1.d3", 32'(d1_digit3), 4);
    frame(4'd1, 4'd2, 4'd3, 4'd4);
    check("f2.fv", 32'(frame_valid), 1);
    check("f2.lock", 32'(locked), 1);
    check_digits("f2", 4'd1, 4'd2, 4'd3, 4'd4);
    step(2'd0, 4'd5);
    check("f3.fv0", 32'(frame_valid), 0);
    step(2'd1, 4'd6);
    step(2'd2, 4'd7);
    step(2'd3, 4'd8);
    check("f3.fv", 32'(frame_valid), 1);
    check_digits("f3", 4'd5, 4'd6, 4'd7, 4'd8);

    // Sequence break 0,1,3.
    step(2'd0, 4'd9);
    step(2'd1, 4'd9);
    step(2'd3, 4'd9);
    check("brk.seq", 32'(seq_err), 1);
    check("brk.lock", 32'(locked), 0);
    check("brk.fv", 32'(frame_valid), 0);
    check_digits("brk", 4'd5, 4'd6, 4'd7, 4'd8);
    frame(4'd2, 4'd4, 4'd6, 4'd8);
    check("rl1.seq", 32'(seq_err), 0);
    check("rl1.fv", 32'(frame_valid), 0);
    check("rl1.lock", 32'(locked), 0);
    frame(4'd2, 4'd4, 4'd6, 4'd8);
    check("rl2.fv", 32'(frame_valid), 1);
    check("rl2.lock", 32'(locked), 1);
    check_digits("rl2", 4'd2, 4'd4, 4'd6, 4'd8);

    // BCD error on digit2 while locked.
    step(2'd0, 4'd1);
    step(2'd1, 4'd1);
    step(2'd2, 4'd12);
    check("bcd.flag", 32'(bcd_err), 1);
    step(2'd3, 4'd1);
    check("bcd.fv", 32'(frame_valid), 0);
    check("bcd.lock", 32'(locked), 1);
    check_digits("bcd", 4'd2, 4'd4, 4'd6, 4'd8);
    frame(4'd3, 4'd1, 4'd4, 4'd1);
    check("bcd2.fv", 32'(frame_valid), 1);
    check("bcd2.sticky", 32'(bcd_err), 1);
    check_digits("bcd2", 4'd3, 4'd1, 4'd4, 4'd1);

    // Long clean run: one pulse per frame, never a seq_err.
    for (int f = 0; f < 1000; f++) begin
      v0 = 4'((f + 0) % 10);
      v1 = 4'((f + 3) % 10);
      v2 = 4'((f + 6) % 10);
      v3 = 4'((f + 9) % 10);
      step(2'd0, v0);
      check("run.fv0", 32'(frame_valid), 0);
      check("run.seq0", 32'(seq_err), 0);
      step(2'd1, v1);
      step(2'd2, v2);
      check("run.fv2", 32'(frame_valid), 0);
      step(2'd3, v3);
      check("run.fv3", 32'(frame_valid), 1);
      check("run.seq3", 32'(seq_err), 0);
      if (f % 97 == 0) check_digits("run", v0, v1, v2, v3);
    end
    check_digits("runend", 4'd9, 4'd2, 4'd5, 4'd8);
    check("runend.lock", 32'(locked), 1);

    // Reset on the commit edge of a locked frame.
    step(2'd0, 4'd4);
    step(2'd1, 4'd4);
    step(2'd2, 4'd4);
    @(negedge clk);
    reset = 1'b1;
    step(2'd3, 4'd4);
    check("rmid.fv", 32'(frame_valid), 0);
    check("rmid.lock", 32'(locked), 0);
    check("rmid.bcd", 32'(bcd_err), 0);
    check("rmid.seq", 32'(seq_err), 0);
    check_digits("rmid", 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    step(2'd1, 4'd4);
    step(2'd2, 4'd4);
    step(2'd3, 4'd4);
    check("post.seq", 32'(seq_err), 0);
    check("post.fv", 32'(frame_valid), 0);
    check("post.lock", 32'(locked), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
